// File: rtl/riscv_privileged_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_privileged_pkg                                                       |
// | Shared M-mode trap types, CSR encodings and mstatus update helpers.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package riscv_privileged_pkg;

  localparam int RV_XLEN  = 64;
  localparam int RV_MXLEN = 64;

  typedef logic [11:0] csr_address_t;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    WRITE_ONLY = 3'd1,
    READ_WRITE = 3'd2,
    SET_BITS   = 3'd3,
    CLEAR_BITS = 3'd4
  } csr_command_t;

  localparam csr_address_t CSR_MSTATUS = 12'h300;
  localparam csr_address_t CSR_MIE     = 12'h304;
  localparam csr_address_t CSR_MTVEC   = 12'h305;
  localparam csr_address_t CSR_MEPC    = 12'h341;
  localparam csr_address_t CSR_MCAUSE  = 12'h342;
  localparam csr_address_t CSR_MTVAL   = 12'h343;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    WR_MSTATUS   = 4'd1,
    WR_MEPC      = 4'd2,
    WR_MCAUSE    = 4'd3,
    WR_MTVAL     = 4'd4,
    REDIRECT     = 4'd5,
    RET_MSTATUS  = 4'd6,
    RET_REDIRECT = 4'd7
  } trap_state_t;

  localparam int IRQ_CODE_W = 4;
  typedef logic [IRQ_CODE_W-1:0] irq_code_t;

  localparam irq_code_t IRQ_MEI = 4'd11;
  localparam irq_code_t IRQ_MSI = 4'd3;
  localparam irq_code_t IRQ_MTI = 4'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam logic [1:0] PRIV_M              = 2'b11;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  function automatic logic [RV_MXLEN-1:0] trap_entry_mstatus(input logic [RV_MXLEN-1:0] status);
    logic [RV_MXLEN-1:0] r;
    r                                = status;
    r[MSTATUS_MPIE]                  = status[MSTATUS_MIE];
    r[MSTATUS_MIE]                   = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  function automatic logic [RV_MXLEN-1:0] trap_return_mstatus(input logic [RV_MXLEN-1:0] status);
    logic [RV_MXLEN-1:0] r;
    r                                = status;
    r[MSTATUS_MIE]                   = status[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                  = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_sequencer_if                                                          |
// | Pipeline/CSR-side bundle of the trap sequencer; slave = sequencer side.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface trap_sequencer_if
  import riscv_privileged_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int MXLEN = RV_MXLEN
);

  logic               exception_valid_i;
  logic [MXLEN-2:0]   exception_cause_i;
  logic [XLEN-1:0]    exception_pc_i;
  logic [MXLEN-1:0]   exception_tval_i;
  logic               mret_i;
  logic               meip_i;
  logic               msip_i;
  logic               mtip_i;
  logic [MXLEN-1:0]   mie_i;
  logic [MXLEN-1:0]   mstatus_i;
  logic [MXLEN-1:0]   mtvec_i;
  logic [XLEN-1:0]    mepc_i;

  csr_address_t       csr_address_o;
  csr_command_t       csr_command_o;
  logic [MXLEN-1:0]   csr_write_data_o;
  logic               trap_ack_o;
  logic               mret_ack_o;
  logic               busy_o;
  logic               redirect_valid_o;
  logic [XLEN-1:0]    redirect_pc_o;

  modport slave (
    input  exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
    input  mret_i, meip_i, msip_i, mtip_i,
    input  mie_i, mstatus_i, mtvec_i, mepc_i,
    output csr_address_o, csr_command_o, csr_write_data_o,
    output trap_ack_o, mret_ack_o, busy_o, redirect_valid_o, redirect_pc_o
  );

  modport master (
    output exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
    output mret_i, meip_i, msip_i, mtip_i,
    output mie_i, mstatus_i, mtvec_i, mepc_i,
    input  csr_address_o, csr_command_o, csr_write_data_o,
    input  trap_ack_o, mret_ack_o, busy_o, redirect_valid_o, redirect_pc_o
  );

endinterface
`default_nettype wire

// File: rtl/trap_irq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_irq_arbiter                                                           |
// | Combinational M-mode interrupt select: MEI > MSI > MTI, gated by mstatus.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trap_irq_arbiter
  import riscv_privileged_pkg::*;
#(
  parameter int MXLEN = RV_MXLEN
) (
  input  logic [MXLEN-1:0] pending,
  input  logic [MXLEN-1:0] mie,
  input  logic             mstatus_mie,
  output logic             irq_valid,
  output irq_code_t        irq_code
);

  logic [MXLEN-1:0] enabled;
  logic             unused_enabled;

  // pending uses the mip layout, so it lines up bit-for-bit with mie
  assign enabled = pending & mie;

  always_comb begin
    irq_valid = 1'b0;
    irq_code  = '0;
    if (mstatus_mie) begin
      if (enabled[MIE_MEIE]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MEI;
      end else if (enabled[MIE_MSIE]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MSI;
      end else if (enabled[MIE_MTIE]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MTI;
      end
    end
  end

  assign unused_enabled = ^{enabled[MXLEN-1:12], enabled[10:8], enabled[6:4], enabled[2:0]};

endmodule
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_sequencer                                                             |
// | Turns exceptions, interrupts and mret into ordered CSR writes + redirect.  |
// | Option macro: TRAP_SEQUENCER_VECTORED_EN (honour mtvec vectored mode).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trap_sequencer
  import riscv_privileged_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int MXLEN = RV_MXLEN
) (
  input  logic              clock_i,
  input  logic              reset_i,
  trap_sequencer_if.slave   bus
);

  trap_state_t      state_q, state_d;
  logic [MXLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0]  pc_q,    pc_d;
  logic [MXLEN-1:0] tval_q,  tval_d;

  logic             irq_valid;
  irq_code_t        irq_code;
  logic [MXLEN-1:0] pending;

  logic             trap_ack;
  logic             mret_ack;
  csr_command_t     csr_command;
  csr_address_t     csr_address;
  logic [MXLEN-1:0] csr_wdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  logic [MXLEN-1:0] trap_base;
  logic [MXLEN-1:0] trap_target_full;
  logic [XLEN-1:0]  trap_target;
  logic             unused_lsbs;

  always_comb begin
    pending           = '0;
    pending[MIE_MEIE] = bus.meip_i;
    pending[MIE_MSIE] = bus.msip_i;
    pending[MIE_MTIE] = bus.mtip_i;
  end

  trap_irq_arbiter #(
    .MXLEN (MXLEN)
  ) u_irq_arbiter (
    .pending     (pending),
    .mie         (bus.mie_i),
    .mstatus_mie (bus.mstatus_i[MSTATUS_MIE]),
    .irq_valid   (irq_valid),
    .irq_code    (irq_code)
  );

  assign trap_base = {bus.mtvec_i[MXLEN-1:2], 2'b00};

`ifdef TRAP_SEQUENCER_VECTORED_EN
  logic vectored_irq;
  // Exceptions always land on the base even in vectored mode
  assign vectored_irq     = (bus.mtvec_i[1:0] == MTVEC_MODE_VECTORED) && cause_q[MXLEN-1];
  assign trap_target_full = vectored_irq
                          ? trap_base + (MXLEN'(cause_q[IRQ_CODE_W-1:0]) << 2)
                          : trap_base;
`else
  logic unused_mode;
  assign unused_mode      = ^bus.mtvec_i[1:0];
  assign trap_target_full = trap_base;
`endif

  assign trap_target = XLEN'(trap_target_full);
  assign unused_lsbs = ^{bus.mepc_i[0], pc_q[0]};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    tval_d         = tval_q;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    csr_command    = NONE;
    csr_address    = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      IDLE: begin
        if (bus.exception_valid_i) begin
          trap_ack = 1'b1;
          cause_d  = {1'b0, bus.exception_cause_i};
          pc_d     = bus.exception_pc_i;
          tval_d   = bus.exception_tval_i;
          state_d  = WR_MSTATUS;
        end else if (irq_valid) begin
          trap_ack = 1'b1;
          cause_d  = {1'b1, {(MXLEN-1-IRQ_CODE_W){1'b0}}, irq_code};
          pc_d     = bus.exception_pc_i;
          tval_d   = '0;
          state_d  = WR_MSTATUS;
        end else if (bus.mret_i) begin
          mret_ack = 1'b1;
          state_d  = RET_MSTATUS;
        end
      end
      WR_MSTATUS: begin
        csr_command = WRITE_ONLY;
        csr_address = CSR_MSTATUS;
        csr_wdata   = trap_entry_mstatus(bus.mstatus_i);
        state_d     = WR_MEPC;
      end
      WR_MEPC: begin
        csr_command = WRITE_ONLY;
        csr_address = CSR_MEPC;
        csr_wdata   = MXLEN'({pc_q[XLEN-1:1], 1'b0});
        state_d     = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        csr_command = WRITE_ONLY;
        csr_address = CSR_MCAUSE;
        csr_wdata   = cause_q;
        state_d     = WR_MTVAL;
      end
      WR_MTVAL: begin
        csr_command = WRITE_ONLY;
        csr_address = CSR_MTVAL;
        csr_wdata   = tval_q;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        state_d        = IDLE;
      end
      RET_MSTATUS: begin
        csr_command = WRITE_ONLY;
        csr_address = CSR_MSTATUS;
        csr_wdata   = trap_return_mstatus(bus.mstatus_i);
        state_d     = RET_REDIRECT;
      end
      RET_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = {bus.mepc_i[XLEN-1:1], 1'b0};
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is held the FSM sits in IDLE, so acks must be masked explicitly
  assign bus.trap_ack_o       = trap_ack & ~reset_i;
  assign bus.mret_ack_o       = mret_ack & ~reset_i;
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.csr_command_o    = csr_command;
  assign bus.csr_address_o    = csr_address;
  assign bus.csr_write_data_o = csr_wdata;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;

endmodule
`default_nettype wire
